// File: rtl/sys_io_pkg.sv
// -----------------------------------------------------------------------------
// sys_io_pkg
// Shared types and constants for the controller frame link between
// controller_tx (transmitter) and sys_io (receiver).
//   controller_t : 24-bit controller snapshot {joystick_x, joystick_y, buttons}
//   START_CHAR   : first byte of every frame
//   TRAILER      : last byte of every frame
//   FRAME_BYTES  : bytes per frame
//   BUTTON_BYTES : one byte per button bit
//   frame_byte() : byte at a given position of the frame for a snapshot
// -----------------------------------------------------------------------------
package sys_io_pkg;

    typedef struct packed {
        logic [7:0] joystick_x;
        logic [7:0] joystick_y;
        logic [7:0] buttons;
    } controller_t;

    localparam logic [7:0] START_CHAR   = 8'hFF;
    localparam logic [7:0] TRAILER      = 8'h00;
    localparam int         FRAME_BYTES  = 12;
    localparam int         BUTTON_BYTES = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SHIFT = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_t;

    // Frame layout: START, buttons[7]..buttons[0] as 0x00/0x01, y, x, TRAILER.
    function automatic logic [7:0] frame_byte(input controller_t c, input logic [3:0] idx);
        logic [7:0] b;
        logic [2:0] bsel;
        b    = TRAILER;
        bsel = 3'(4'd8 - idx);
        case (idx)
            4'd0:                       b = START_CHAR;
            4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8:     b = {7'd0, c.buttons[bsel]};
            4'd9:                       b = c.joystick_y;
            4'd10:                      b = c.joystick_x;
            default:                    b = TRAILER;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// -----------------------------------------------------------------------------
// spi_byte_tx
// Shifts one byte out MSB first. Data changes only while SCLK is low; SCLK
// rises CLK_DIV cycles after a bit is presented and falls CLK_DIV cycles later,
// presenting the next bit on that same falling edge. After the eighth falling
// edge the data line returns to 0 and done_out pulses for one cycle.
//   clk_in    : system clock
//   rst_in    : synchronous active-high reset
//   load_in   : start a byte; bit7 appears on the same edge
//   byte_in   : byte to send, sampled when load_in=1
//   done_out  : one-cycle pulse, coincident with the final SCLK fall
//   sclk_out  : serial clock, idles low
//   sdata_out : serial data, idles low
// -----------------------------------------------------------------------------
module spi_byte_tx
    import sys_io_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       load_in,
    input  logic [7:0] byte_in,
    output logic       done_out,
    output logic       sclk_out,
    output logic       sdata_out
);

    localparam int          HW        = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic          r_active;
    logic          r_sclk;
    logic          r_sdata;
    logic          r_done;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bit_cnt;
    logic [HW-1:0] r_half_cnt;

    // Half-period timing, bit shifting and end-of-byte pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_active   <= 1'b0;
            r_sclk     <= 1'b0;
            r_sdata    <= 1'b0;
            r_done     <= 1'b0;
            r_shreg    <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_half_cnt <= {HW{1'b0}};
        end else begin
            r_done <= 1'b0;
            if (load_in) begin
                r_active   <= 1'b1;
                r_shreg    <= byte_in;
                r_sdata    <= byte_in[7];
                r_sclk     <= 1'b0;
                r_bit_cnt  <= 3'd0;
                r_half_cnt <= {HW{1'b0}};
            end else if (r_active) begin
                if (r_half_cnt == HALF_LAST) begin
                    r_half_cnt <= {HW{1'b0}};
                    if (!r_sclk) begin
                        r_sclk <= 1'b1;
                    end else begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt == 3'd7) begin
                            // Last fall: release the data line for the gap.
                            r_active <= 1'b0;
                            r_sdata  <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shreg   <= {r_shreg[6:0], 1'b0};
                            r_sdata   <= r_shreg[6];
                        end
                    end
                end else begin
                    r_half_cnt <= r_half_cnt + HW'(1);
                end
            end
        end
    end

    assign done_out  = r_done;
    assign sclk_out  = r_sclk;
    assign sdata_out = r_sdata;

endmodule

// File: rtl/controller_tx.sv
// -----------------------------------------------------------------------------
// controller_tx
// Serialises a controller_t snapshot into the 12-byte controller frame
// (START, 8 button bytes, y, x, TRAILER) on a 2-wire SCLK/data link, with an
// idle gap of GAP_CYCLES after every byte.
//   clk_in        : system clock
//   rst_in        : synchronous active-high reset, abandons any frame
//   controller_in : snapshot, latched only on the accept cycle
//   send_in       : frame request, accepted only while idle
//   busy_out      : frame in progress
//   done_out      : one-cycle pulse when the frame completes
//   chip_data_out : serial data, MSB first
//   chip_clk_out  : serial clock, idles low
// -----------------------------------------------------------------------------
module controller_tx
    import sys_io_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 100
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  controller_t controller_in,
    input  logic        send_in,
    output logic        busy_out,
    output logic        done_out,
    output logic        chip_data_out,
    output logic        chip_clk_out
);

    localparam int            GW       = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic          GAP_ONE  = (GAP_CYCLES == 1);
    localparam logic [3:0]    LAST_IDX = 4'(FRAME_BYTES - 1);

    tx_state_t     r_state;
    tx_state_t     w_next_state;
    controller_t   r_frame;
    logic [3:0]    r_byte_idx;
    logic [GW-1:0] r_gap_cnt;
    logic          r_busy;
    logic          r_done;

    logic          w_spi_done;
    logic          w_accept;
    logic          w_gap_end;
    logic          w_last_byte;
    logic          w_load;
    logic [7:0]    w_byte;

    spi_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_spi (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load_in   (w_load),
        .byte_in   (w_byte),
        .done_out  (w_spi_done),
        .sclk_out  (chip_clk_out),
        .sdata_out (chip_data_out)
    );

    // The cycle in which the byte engine reports done is gap cycle 0, so the
    // gap ends either right there (GAP_CYCLES=1) or when the GAP count hits its last value.
    assign w_accept    = (r_state == TX_IDLE) && send_in;
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    assign w_gap_end   = ((r_state == TX_SHIFT) && w_spi_done && GAP_ONE) ||
                         ((r_state == TX_GAP) && (r_gap_cnt == GAP_LAST));

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            TX_IDLE: begin
                if (send_in) begin
                    w_next_state = TX_SHIFT;
                end else begin
                    w_next_state = TX_IDLE;
                end
            end
            TX_SHIFT: begin
                if (w_gap_end) begin
                    w_next_state = w_last_byte ? TX_IDLE : TX_SHIFT;
                end else if (w_spi_done) begin
                    w_next_state = TX_GAP;
                end else begin
                    w_next_state = TX_SHIFT;
                end
            end
            TX_GAP: begin
                if (w_gap_end) begin
                    w_next_state = w_last_byte ? TX_IDLE : TX_SHIFT;
                end else begin
                    w_next_state = TX_GAP;
                end
            end
            default: w_next_state = TX_IDLE;
        endcase
    end

    // FSM outputs: byte-engine load strobe and the byte to load.
    always_comb begin
        w_load = 1'b0;
        w_byte = TRAILER;
        case (r_state)
            TX_IDLE: begin
                if (send_in) begin
                    w_load = 1'b1;
                    w_byte = frame_byte(controller_in, 4'd0);
                end else begin
                    w_load = 1'b0;
                end
            end
            TX_SHIFT, TX_GAP: begin
                if (w_gap_end && !w_last_byte) begin
                    w_load = 1'b1;
                    w_byte = frame_byte(r_frame, r_byte_idx + 4'd1);
                end else begin
                    w_load = 1'b0;
                end
            end
            default: begin
                w_load = 1'b0;
                w_byte = TRAILER;
            end
        endcase
    end

    // Frame latch, byte index, gap counter and handshake outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_frame    <= '{joystick_x: 8'd0, joystick_y: 8'd0, buttons: 8'd0};
            r_byte_idx <= 4'd0;
            r_gap_cnt  <= {GW{1'b0}};
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_frame    <= controller_in;
                r_byte_idx <= 4'd0;
                r_gap_cnt  <= {GW{1'b0}};
                r_busy     <= 1'b1;
            end else if (w_gap_end) begin
                r_gap_cnt <= {GW{1'b0}};
                if (w_last_byte) begin
                    r_byte_idx <= 4'd0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                end else begin
                    r_byte_idx <= r_byte_idx + 4'd1;
                end
            end else if ((r_state == TX_SHIFT) && w_spi_done) begin
                r_gap_cnt <= GW'(1);
            end else if (r_state == TX_GAP) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end else begin
                r_gap_cnt <= r_gap_cnt;
            end
        end
    end

    assign busy_out = r_busy;
    assign done_out = r_done;

endmodule

// File: tb/tb_controller_tx.sv
module tb_controller_tx;
    import sys_io_pkg::*;

    localparam int CLK_DIV   = 2;
    localparam int GAP       = 4;
    localparam int FRAME_CYC = 12 * (16 * CLK_DIV + GAP);

    logic        clk;
    logic        rst_in;
    controller_t controller_in;
    logic        send_in;
    logic        busy_out;
    logic        done_out;
    logic        chip_data_out;
    logic        chip_clk_out;

    controller_tx #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP)) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .controller_in (controller_in),
        .send_in       (send_in),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .chip_data_out (chip_data_out),
        .chip_clk_out  (chip_clk_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Receiver-side monitor: sample data on SCLK rising edges, measure high phases.
    logic [7:0] rx_q[$];
    logic [7:0] mon_sh;
    int         mon_bits = 0;
    logic       prev_sclk = 1'b0;
    int         hi_len = 0;
    int         hi_min = 1000;
    int         hi_max = 0;

    always @(negedge clk) begin
        if (rst_in || !busy_out) begin
            mon_bits  = 0;
            hi_len    = 0;
            prev_sclk = 1'b0;
        end else begin
            if (chip_clk_out && !prev_sclk) begin
                mon_sh   = {mon_sh[6:0], chip_data_out};
                mon_bits = mon_bits + 1;
                if (mon_bits == 8) begin
                    rx_q.push_back(mon_sh);
                    mon_bits = 0;
                end
            end
            if (chip_clk_out) begin
                hi_len = hi_len + 1;
            end else if (prev_sclk) begin
                if (hi_len < hi_min) hi_min = hi_len;
                if (hi_len > hi_max) hi_max = hi_len;
                hi_len = 0;
            end
            prev_sclk = chip_clk_out;
        end
    end

    // Reference frame built from the byte-level description of the link.
    logic [7:0] exp_b[12];

    task automatic build_expected(input logic [7:0] x, input logic [7:0] y, input logic [7:0] btn);
        exp_b[0] = 8'hFF;
        for (int i = 0; i < 8; i++) exp_b[1 + i] = btn[7 - i] ? 8'h01 : 8'h00;
        exp_b[9]  = y;
        exp_b[10] = x;
        exp_b[11] = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_frame(input string tag, input int base);
        logic [31:0] got;
        for (int i = 0; i < 12; i++) begin
            got = (base + i < rx_q.size()) ? {24'd0, rx_q[base + i]} : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, i), got, {24'd0, exp_b[i]});
        end
    endtask

    int acc;
    int dcyc;

    // Raise send_in for one accept edge and check the accept-edge outputs.
    task automatic send_frame(input controller_t c);
        @(negedge clk);
        controller_in = c;
        send_in       = 1'b1;
        acc           = cyc + 1;
        @(negedge clk);
        send_in = 1'b0;
        check("accept_busy", {31'd0, busy_out}, 32'd1);
        check("accept_data", {31'd0, chip_data_out}, 32'd1);
    endtask

    task automatic wait_done(input int budget, output int d);
        d = -1;
        for (int i = 0; i < budget; i++) begin
            if (done_out) begin
                d = cyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    controller_t c;
    logic        ok;
    int          d1;
    int          dcount;

    initial begin
        rst_in        = 1'b1;
        send_in       = 1'b0;
        controller_in = '{joystick_x: 8'd0, joystick_y: 8'd0, buttons: 8'd0};
        repeat (3) @(negedge clk);
        check("rst_sclk", {31'd0, chip_clk_out}, 32'd0);
        check("rst_data", {31'd0, chip_data_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_done", {31'd0, done_out}, 32'd0);
        rst_in = 1'b0;

        // Idle for 500 cycles: everything stays low.
        ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (chip_clk_out || chip_data_out || busy_out || done_out) ok = 1'b0;
        end
        check("idle_quiet", {31'd0, ok}, 32'd1);

        // Directed frame.
        rx_q.delete();
        hi_min = 1000;
        hi_max = 0;
        c = '{joystick_x: 8'h12, joystick_y: 8'h34, buttons: 8'hA5};
        build_expected(8'h12, 8'h34, 8'hA5);
        send_frame(c);
        wait_done(FRAME_CYC + 50, dcyc);
        check("dir_latency", dcyc - acc, FRAME_CYC);
        check("dir_busy_at_done", {31'd0, busy_out}, 32'd0);
        repeat (2) @(negedge clk);
        check("dir_count", rx_q.size(), 12);
        check_frame("dir", 0);
        check("hi_min", hi_min, CLK_DIV);
        check("hi_max", hi_max, CLK_DIV);

        // Random frames.
        for (int r = 0; r < 3; r++) begin
            rx_q.delete();
            c.joystick_x = 8'($urandom);
            c.joystick_y = 8'($urandom);
            c.buttons    = 8'($urandom);
            build_expected(c.joystick_x, c.joystick_y, c.buttons);
            send_frame(c);
            wait_done(FRAME_CYC + 50, dcyc);
            check("rnd_latency", dcyc - acc, FRAME_CYC);
            repeat (2) @(negedge clk);
            check("rnd_count", rx_q.size(), 12);
            check_frame("rnd", 0);
        end

        // Back-to-back all-0xFF frames with send_in held high.
        rx_q.delete();
        c = '{joystick_x: 8'hFF, joystick_y: 8'hFF, buttons: 8'hFF};
        build_expected(8'hFF, 8'hFF, 8'hFF);
        @(negedge clk);
        controller_in = c;
        send_in       = 1'b1;
        acc           = cyc + 1;
        @(negedge clk);
        wait_done(FRAME_CYC + 50, d1);
        check("b2b_lat1", d1 - acc, FRAME_CYC);
        @(negedge clk);
        check("b2b_restart_busy", {31'd0, busy_out}, 32'd1);
        check("b2b_restart_data", {31'd0, chip_data_out}, 32'd1);
        wait_done(FRAME_CYC + 50, dcyc);
        send_in = 1'b0;
        check("b2b_lat2", dcyc - d1, FRAME_CYC + 1);
        @(negedge clk);
        check("b2b_stop", {31'd0, busy_out}, 32'd0);
        repeat (2) @(negedge clk);
        check("b2b_count", rx_q.size(), 24);
        check_frame("b2b_f1", 0);
        check_frame("b2b_f2", 12);

        // Mid-frame request with a changed snapshot is ignored.
        rx_q.delete();
        c = '{joystick_x: 8'h5A, joystick_y: 8'hC3, buttons: 8'h3C};
        build_expected(8'h5A, 8'hC3, 8'h3C);
        send_frame(c);
        ok   = 1'b1;
        dcyc = -1;
        for (int i = 0; i < FRAME_CYC + 50; i++) begin
            if (done_out) begin
                dcyc = cyc;
                break;
            end
            if (!busy_out) ok = 1'b0;
            if (i == 100) begin
                controller_in = '{joystick_x: 8'h01, joystick_y: 8'h02, buttons: 8'h00};
                send_in       = 1'b1;
            end
            if (i == 101) send_in = 1'b0;
            @(negedge clk);
        end
        check("mid_busy_held", {31'd0, ok}, 32'd1);
        check("mid_latency", dcyc - acc, FRAME_CYC);
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_out || done_out) ok = 1'b0;
        end
        check("mid_no_second", {31'd0, ok}, 32'd1);
        check("mid_count", rx_q.size(), 12);
        check_frame("mid", 0);

        // Reset during byte 5 while SCLK is high.
        rx_q.delete();
        c = '{joystick_x: 8'h77, joystick_y: 8'h88, buttons: 8'h99};
        send_frame(c);
        ok = 1'b0;
        for (int i = 0; i < FRAME_CYC; i++) begin
            if (rx_q.size() == 5 && !chip_clk_out) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 4 * CLK_DIV + GAP; i++) begin
            if (chip_clk_out) break;
            @(negedge clk);
        end
        check("rst_reached_byte5", {31'd0, ok && chip_clk_out}, 32'd1);
        rst_in = 1'b1;
        @(negedge clk);
        rst_in = 1'b0;
        check("midrst_sclk", {31'd0, chip_clk_out}, 32'd0);
        check("midrst_busy", {31'd0, busy_out}, 32'd0);
        check("midrst_data", {31'd0, chip_data_out}, 32'd0);
        dcount = 0;
        for (int i = 0; i < 600; i++) begin
            if (done_out || busy_out) dcount++;
            @(negedge clk);
        end
        check("midrst_no_done", dcount, 0);

        rx_q.delete();
        c = '{joystick_x: 8'hE1, joystick_y: 8'h1E, buttons: 8'h81};
        build_expected(8'hE1, 8'h1E, 8'h81);
        send_frame(c);
        wait_done(FRAME_CYC + 50, dcyc);
        check("post_rst_latency", dcyc - acc, FRAME_CYC);
        repeat (2) @(negedge clk);
        check("post_rst_count", rx_q.size(), 12);
        check_frame("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/controller_tx.md
Name: controller_tx

Overview:
- SPI-style transmitter that serializes a controller_t snapshot into the 2-wire controller frame consumed by sys_io.
- Drives chip_clk/chip_data as bus master.
- Used for console-to-console controller forwarding and as the loopback stimulus source in sys_io regressions.
- One frame is sent per send_in request.

Parameters:
- CLK_DIV, 50: clk_in cycles per half-period of chip_clk_out (1 MHz SCLK at 100 MHz); must be >= 1.
- GAP_CYCLES, 100: idle clk_in cycles after each byte (SCLK low, data low); must be >= 1.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- controller_in  input  24 (controller_t)  snapshot to send; sampled only on the accept cycle
- send_in  input  1  request a frame; accepted only when busy_out=0
- busy_out  output  1  frame in progress
- done_out  output  1  one-cycle pulse when a frame completes
- chip_data_out  output  1  serial data, MSB first
- chip_clk_out  output  1  serial clock; idles low

Behaviour:
- Reset: busy_out=0, done_out=0, chip_data_out=0, chip_clk_out=0, FSM=IDLE, all counters 0.
  - Reset mid-frame abandons the frame; outputs reach reset values on the next edge.
- Frame: 12 bytes, in order:
  - START_CHAR 0xFF
  - 8 button bytes 0x00/0x01, one per bit, buttons[7] first, buttons[0] last
  - joystick_y
  - joystick_x
  - TRAILER 0x00
- Accept: at an edge where FSM=IDLE and send_in=1:
  - latch controller_in into an internal frame register
  - busy_out=1 from that edge
  - chip_data_out = bit7 of byte 0 from that edge
  - Later changes to controller_in do not affect the frame in flight.
- send_in while busy_out=1 is ignored; requests are not queued.
- Bit timing per byte:
  - data set up with SCLK low
  - SCLK rises after CLK_DIV cycles; the receiver samples on the rising edge
  - SCLK falls after another CLK_DIV cycles; the next bit is presented on that same edge
  - 8 bits take 16*CLK_DIV cycles and end with SCLK low
- After each byte: GAP_CYCLES with SCLK low and data 0. Then the next byte's bit7 is presented.
- Frame latency: done_out pulses exactly 12*(16*CLK_DIV+GAP_CYCLES) cycles after the accept edge.
  - In that same cycle busy_out=0 and FSM=IDLE.
  - send_in in the done_out cycle is accepted, so back-to-back frames are possible.
- FSM states and transitions:
  - IDLE: accept → SHIFT.
  - SHIFT: 8 bits via bit counter 0..7 and half-period counter 0..CLK_DIV-1 → GAP.
  - GAP: counter 0..GAP_CYCLES-1. Then byte index 11 → IDLE with done_out, otherwise byte index +1 → SHIFT.
- Byte index counts 0..11 and never wraps mid-frame.
- Half-period and gap counters are wide enough for each parameter; no overflow at maximum values.
- 0xFF joystick values are legal. Framing relies on the receiver searching for START only while idle; the transmitter never escapes data.

Decomposition:
- Shared package sys_io_pkg holds:
  - controller_t (moved from sys_io, which imports the package)
  - START_CHAR=8'hFF
  - TRAILER=8'h00
  - FRAME_BYTES=12
  - BUTTON_BYTES=8
- Sub-module spi_byte_tx (CLK_DIV):
  - inputs: load_in, byte_in[7:0]
  - outputs: done_out pulse, sclk, sdata
- controller_tx owns frame sequencing, gap timing and handshakes.

Test Plan:
- Reset then idle, 500 cycles → chip_clk_out, chip_data_out, busy_out and done_out stay 0.
- CLK_DIV=2, GAP_CYCLES=4, send controller {x=0x12, y=0x34, buttons=0xA5}:
  - decoded bytes are FF,01,00,01,00,00,01,00,01,34,12,00
  - done_out pulses exactly 432 cycles after accept
  - each SCLK high phase lasts 2 cycles
- Loopback into sys_io with joystick_x=0xFF, y=0xFF, buttons=0xFF, two back-to-back frames (send_in held high):
  - sys_io joystick fields read 0xFF/0xFF
  - second frame starts the cycle after done_out with no extra gap
- Change controller_in and pulse send_in mid-frame → transmitted bytes match the original latch, no second frame, busy_out stays 1.
- Assert rst_in during byte 5, SCLK high:
  - next edge: chip_clk_out=0, busy_out=0, done_out never pulses
  - a new send_in afterwards produces a clean full frame beginning 0xFF
